// File: rtl/seg7_rx_monitor.sv
// seg7_rx_monitor: receive-side self-check for an active-low 7-segment digit
// driven by a decimal seconds counter. The segment lines are synchronised and
// filtered for stability. Each newly stable pattern is decoded back to a digit,
// checked against the mod-10 increment sequence, and sequence and pattern
// errors are counted in a saturating counter.
//
// Optional build macro SEG7_RX_HEXA_EN: when defined, the hex letters A..F
// also decode, and the expected-next rule becomes a 4-bit wrap (15 -> 0).
module seg7_rx_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [6:0]       HEX_IN,
  output logic [3:0]       DIGIT,
  output logic             VALID,
  output logic             UPD,
  output logic             SEQ_ERR,
  output logic             ILLEGAL,
  output logic             BLANK,
  output logic [ERR_W-1:0] ERR_CNT
);

  localparam logic [6:0]       PAT_BLANK = 7'h7F;
  localparam logic [7:0]       STABLE_M1 = 8'(STABLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  typedef enum logic {S_INIT, S_TRACK} state_t;

  state_t           state, state_n;
  logic [6:0]       h1, h2, last;
  logic [7:0]       stab_cnt;
  logic             accept;
  logic [4:0]       dec;
  logic [3:0]       digit_n;
  logic             valid_n, upd_n, seq_err_n, illegal_n, blank_n;
  logic [ERR_W-1:0] err_cnt_n;

  // Map an active-low gfedcba pattern to {legal, digit}; blank counts as not legal.
  function automatic logic [4:0] decode(input logic [6:0] pat);
    case (pat)
      7'h40:   decode = 5'h10;
      7'h79:   decode = 5'h11;
      7'h24:   decode = 5'h12;
      7'h30:   decode = 5'h13;
      7'h19:   decode = 5'h14;
      7'h12:   decode = 5'h15;
      7'h02:   decode = 5'h16;
      7'h78:   decode = 5'h17;
      7'h00:   decode = 5'h18;
      7'h10:   decode = 5'h19;
`ifdef SEG7_RX_HEXA_EN
      7'h08:   decode = 5'h1A;
      7'h03:   decode = 5'h1B;
      7'h46:   decode = 5'h1C;
      7'h21:   decode = 5'h1D;
      7'h06:   decode = 5'h1E;
      7'h0E:   decode = 5'h1F;
`endif
      default: decode = 5'h00;
    endcase
  endfunction

  // Digit the counter should show after d.
  function automatic logic [3:0] next_digit(input logic [3:0] d);
`ifdef SEG7_RX_HEXA_EN
    next_digit = d + 4'd1;
`else
    next_digit = (d == 4'd9) ? 4'd0 : d + 4'd1;
`endif
  endfunction

  // Two-flop synchroniser plus a stability counter that restarts whenever h2 is about to change.
  always_ff @(posedge CLK) begin
    if (RST) begin
      h1       <= PAT_BLANK;
      h2       <= PAT_BLANK;
      stab_cnt <= 8'd0;
    end else begin
      h1 <= HEX_IN;
      h2 <= h1;
      if (h1 != h2)
        stab_cnt <= 8'd0;
      else if (stab_cnt != 8'hFF)
        stab_cnt <= stab_cnt + 8'd1;
    end
  end

  // Accept once: h2 has been constant for the full window and differs from the last accepted pattern.
  assign accept = (h1 == h2) && (stab_cnt == STABLE_M1) && (h2 != last);

  // State, last-accepted pattern and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_INIT;
      last    <= PAT_BLANK;
      DIGIT   <= 4'd0;
      VALID   <= 1'b0;
      UPD     <= 1'b0;
      SEQ_ERR <= 1'b0;
      ILLEGAL <= 1'b0;
      BLANK   <= 1'b0;
      ERR_CNT <= '0;
    end else begin
      state   <= state_n;
      if (accept)
        last <= h2;
      DIGIT   <= digit_n;
      VALID   <= valid_n;
      UPD     <= upd_n;
      SEQ_ERR <= seq_err_n;
      ILLEGAL <= illegal_n;
      BLANK   <= blank_n;
      ERR_CNT <= err_cnt_n;
    end
  end

  // Next-state and output decisions, evaluated only when a pattern is accepted.
  always_comb begin
    state_n   = state;
    digit_n   = DIGIT;
    valid_n   = VALID;
    illegal_n = ILLEGAL;
    blank_n   = BLANK;
    upd_n     = 1'b0;
    seq_err_n = 1'b0;
    dec       = decode(h2);
    if (accept) begin
      upd_n = 1'b1;
      if (dec[4]) begin
        digit_n   = dec[3:0];
        valid_n   = 1'b1;
        illegal_n = 1'b0;
        blank_n   = 1'b0;
        state_n   = S_TRACK;
        // Out-of-sequence digit: flag it and resynchronise to the new value.
        if ((state == S_TRACK) && (dec[3:0] != next_digit(DIGIT)))
          seq_err_n = 1'b1;
      end else if (h2 == PAT_BLANK) begin
        blank_n   = 1'b1;
        illegal_n = 1'b0;
        valid_n   = 1'b0;
        state_n   = S_INIT;
      end else begin
        illegal_n = 1'b1;
        blank_n   = 1'b0;
        valid_n   = 1'b0;
        seq_err_n = 1'b1;
        state_n   = S_INIT;
      end
    end
    err_cnt_n = (seq_err_n && (ERR_CNT != ERR_MAX)) ? ERR_CNT + ERR_W'(1) : ERR_CNT;
  end

endmodule

// File: tb/tb_seg7_rx_monitor.sv
// Directed bench for seg7_rx_monitor: a main instance (ERR_W=8) and a narrow
// instance (ERR_W=2) share all stimulus; the narrow one shows counter saturation.
module tb_seg7_rx_monitor;

  logic       CLK = 1'b0;
  logic       RST;
  logic [6:0] HEX_IN;

  logic [3:0] DIGIT, DIGIT2;
  logic       VALID, UPD, SEQ_ERR, ILLEGAL, BLANK;
  logic       VALID2, UPD2, SEQ_ERR2, ILLEGAL2, BLANK2;
  logic [7:0] ERR_CNT;
  logic [1:0] ERR_CNT2;

  int checks = 0;
  int errors = 0;

  seg7_rx_monitor #(.STABLE_CYCLES(4), .ERR_W(8)) dut (
    .CLK(CLK), .RST(RST), .HEX_IN(HEX_IN), .DIGIT(DIGIT), .VALID(VALID),
    .UPD(UPD), .SEQ_ERR(SEQ_ERR), .ILLEGAL(ILLEGAL), .BLANK(BLANK), .ERR_CNT(ERR_CNT)
  );

  seg7_rx_monitor #(.STABLE_CYCLES(4), .ERR_W(2)) dut2 (
    .CLK(CLK), .RST(RST), .HEX_IN(HEX_IN), .DIGIT(DIGIT2), .VALID(VALID2),
    .UPD(UPD2), .SEQ_ERR(SEQ_ERR2), .ILLEGAL(ILLEGAL2), .BLANK(BLANK2), .ERR_CNT(ERR_CNT2)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [3:0] e_dig, input logic e_vld,
                           input logic e_ill, input logic e_blk, input int e_cnt);
    chk({tag, ".DIGIT"},   32'(DIGIT),    32'(e_dig));
    chk({tag, ".VALID"},   32'(VALID),    32'(e_vld));
    chk({tag, ".ILLEGAL"}, 32'(ILLEGAL),  32'(e_ill));
    chk({tag, ".BLANK"},   32'(BLANK),    32'(e_blk));
    chk({tag, ".ERR_CNT"}, 32'(ERR_CNT),  32'(e_cnt));
    chk({tag, ".ERR_CNT2"}, 32'(ERR_CNT2), 32'((e_cnt > 3) ? 3 : e_cnt));
  endtask

  // Apply a pattern for ncyc edges; when acc is set, UPD (and SEQ_ERR if err)
  // must pulse exactly in the cycle after edge 6 and nowhere else.
  task automatic drive(input string tag, input logic [6:0] pat, input int ncyc, input logic acc,
                       input logic [3:0] e_dig, input logic e_vld, input logic e_err,
                       input logic e_ill, input logic e_blk, input int e_cnt);
    HEX_IN = pat;
    for (int i = 1; i <= ncyc; i++) begin
      @(posedge CLK); #1;
      chk({tag, ".UPD"},     32'(UPD),      32'(acc && (i == 6)));
      chk({tag, ".SEQ_ERR"}, 32'(SEQ_ERR),  32'(acc && e_err && (i == 6)));
      chk({tag, ".SEQ_ERR2"}, 32'(SEQ_ERR2), 32'(acc && e_err && (i == 6)));
    end
    chk_state(tag, e_dig, e_vld, e_ill, e_blk, e_cnt);
  endtask

  initial begin
    // Reset with blank input held.
    RST = 1'b1;
    HEX_IN = 7'h7F;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      chk("rst.UPD", 32'(UPD), 32'(0));
    end
    chk("rst.SEQ_ERR", 32'(SEQ_ERR), 32'(0));
    chk_state("rst", 4'd0, 1'b0, 1'b0, 1'b0, 0);
    RST = 1'b0;
    drive("idle_blank", 7'h7F, 10, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Full walk 0..9 and wrap to 0.
    drive("walk0", 7'h40, 10, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    drive("walk1", 7'h79, 10, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    drive("walk2", 7'h24, 10, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    drive("walk3", 7'h30, 10, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    drive("walk4", 7'h19, 10, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    drive("walk5", 7'h12, 10, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    drive("walk6", 7'h02, 10, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    drive("walk7", 7'h78, 10, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    drive("walk8", 7'h00, 10, 1'b1, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    drive("walk9", 7'h10, 10, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    drive("wrap0", 7'h40, 10, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 0);

    // Advance to 3, then a short glitch that returns to 3.
    drive("to1", 7'h79, 10, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    drive("to2", 7'h24, 10, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    drive("to3", 7'h30, 10, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    drive("glitch", 7'h19, 2, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    drive("glitch_back", 7'h30, 10, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 0);

    // Skip from 3 to 5, then in-sequence 6.
    drive("skip5", 7'h12, 10, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1);
    drive("seq6", 7'h02, 10, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1);

    // Blank, illegal, then a fresh start at 0.
    drive("blank", 7'h7F, 10, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    drive("illegal", 7'h55, 10, 1'b1, 4'd6, 1'b0, 1'b1, 1'b1, 1'b0, 2);
    drive("restart0", 7'h40, 10, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2);

    // Five out-of-sequence digits; the narrow counter stops at 3.
    drive("oos1", 7'h30, 10, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 3);
    drive("oos2", 7'h40, 10, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4);
    drive("oos3", 7'h30, 10, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 5);
    drive("oos4", 7'h40, 10, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 6);
    drive("oos5", 7'h30, 10, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 7);

    // Reset in the middle of a stability window aborts the pending acceptance.
    HEX_IN = 7'h79;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      chk("midwin.UPD", 32'(UPD), 32'(0));
    end
    RST = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK); #1;
      chk("midrst.UPD", 32'(UPD), 32'(0));
    end
    RST = 1'b0;
    chk_state("after_rst", 4'd0, 1'b0, 1'b0, 1'b0, 0);
    drive("post_rst1", 7'h79, 10, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_rx_monitor.md
Name: seg7_rx_monitor

Overview:
Receive-side checker for a single active-low 7-segment digit bus that is driven by a decimal seconds counter. It synchronises and debounces the segment lines, then decodes each stable pattern back to BCD. It also checks that successive digits follow the mod-10 increment sequence and counts sequence and pattern errors. It sits on the board or test harness next to the display driver as a self-check monitor.

Parameters:
STABLE_CYCLES, 4, number of consecutive identical synchronised samples required before a pattern is accepted (legal range 1..255)
ERR_W, 8, width of the saturating error counter

Ports:
CLK  input  1  system clock
RST  input  1  synchronous, active-high reset
HEX_IN  input  7  segment lines, bit order gfedcba, 0 = segment lit
DIGIT  output  4  last accepted legal digit
VALID  output  1  DIGIT holds a legal decoded value
UPD  output  1  one-cycle pulse when a new pattern is accepted
SEQ_ERR  output  1  one-cycle pulse, coincident with UPD, on a sequence or illegal-pattern error
ILLEGAL  output  1  last accepted pattern was not a legal digit or blank
BLANK  output  1  last accepted pattern was 7'h7F (all segments off)
ERR_CNT  output  ERR_W  saturating count of SEQ_ERR pulses

Behaviour:
Reset values (clock CLK; reset RST, synchronous, active-high):
- DIGIT=0, VALID=0, UPD=0, SEQ_ERR=0, ILLEGAL=0, BLANK=0, ERR_CNT=0.
- Both synchroniser stages and the last-accepted pattern register reset to 7'h7F.
- Stability counter resets to 0; FSM resets to S_INIT.

Synchroniser and stability filter:
- HEX_IN passes through a 2-flop synchroniser, h1 then h2.
- The stability counter clears whenever h2 differs from its previous value; otherwise it increments and saturates.
- A pattern is accepted exactly once per stable period: when h2 has been constant for STABLE_CYCLES samples and differs from the last accepted pattern.
- A glitch that returns to the last accepted pattern produces no acceptance.

Latency:
- HEX_IN changes before edge 1 and is held.
- UPD is high in the cycle following edge STABLE_CYCLES+2.
- DIGIT, VALID, ILLEGAL and BLANK update on that same edge.

Decode table (hex value of gfedcba -> digit):
40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9; 7F is blank; anything else is illegal.

FSM (evaluated only on acceptance):
- S_INIT, legal digit d: DIGIT=d, VALID=1, no error, go to S_TRACK.
- S_TRACK, legal d equal to the expected next value (DIGIT==9 ? 0 : DIGIT+1): DIGIT=d, no error.
- S_TRACK, legal d not equal to the expected value: DIGIT=d, SEQ_ERR pulse, remain in S_TRACK (resynchronise to d).
- Any state, blank: BLANK=1, VALID=0, DIGIT held, no error, go to S_INIT.
- Any state, illegal pattern: ILLEGAL=1, VALID=0, SEQ_ERR pulse, DIGIT held, go to S_INIT.
- BLANK and ILLEGAL clear on the next legal acceptance.

Error counter:
- ERR_CNT increments on each SEQ_ERR and saturates at 2^ERR_W-1.
- Further errors while saturated still pulse SEQ_ERR.

Other boundary conditions:
- Reset asserted mid-filter aborts any pending acceptance; nothing is accepted until the full stability window elapses after reset release.
- Width rules: the digit comparison is 4-bit; the stability counter is 8-bit.

Optional Feature:
Macro SEG7_RX_HEXA_EN.
- Defined: additionally decodes 08->A, 03->b, 46->C, 21->d, 06->E, 0E->F. The expected-next rule wraps 15->0, and 9->10 is legal.
- Undefined: those six patterns are illegal, and the sequence wraps 9->0.

Test Plan:
- RST high 3 cycles, HEX_IN=7F held -> all outputs 0, no UPD.
- Drive 40, 79, 24 … 10, 40, each held 10 cycles, STABLE_CYCLES=4 -> UPD on each change at edge 6, DIGIT walks 0..9..0, VALID=1, ERR_CNT=0.
- DIGIT=3 stable; drive 19 (4) for 2 cycles, then back to 30 -> no UPD, DIGIT stays 3.
- DIGIT=3; drive 12 (5) -> SEQ_ERR pulse with UPD, DIGIT=5, ERR_CNT=1; then 02 (6) -> no error.
- Drive 7F, then 0x55, then 40 -> BLANK=1 with VALID=0; then ILLEGAL=1 with SEQ_ERR pulse and ERR_CNT +1; then DIGIT=0, VALID=1 with no error.
- ERR_W=2, 5 out-of-sequence digits -> ERR_CNT stops at 3, 5 SEQ_ERR pulses; RST mid-window -> no UPD, ERR_CNT=0.
